load_store_ctrl: RTL and testbench
==================================

# load_store_ctrl

Parametrised, handshaked load/store controller between the CPU datapath and a word-organised memory/peripheral bus. It accepts one byte, half or word (or doubleword when XLEN=64) access per request, drives byte enables and lane-shifted write data, sign- or zero-extends read data, and reports misalignment, illegal size and bus timeout. The block supports variable bus latency through an ack handshake, so the decoder stalls on `req_ready`/`resp_valid` instead of assuming fixed-latency memory.

## Interface
- XLEN, 32: data width; legal values 32 or 64.
- ADDR_W, 32: byte address width.
- TIMEOUT, 15: maximum cycles waiting for `bus_ack`; legal range 1..255.
- CLK  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request strobe.
- req_ready  out  1  block can accept a request.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  3  funct3 encoding; [1:0] = log2(bytes), [2] = unsigned load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  2  0 = OK, 1 = misaligned, 2 = timeout, 3 = illegal size.
- bus_en  out  1  bus access active.
- bus_wr  out  1  bus write.
- bus_addr  out  ADDR_W  word-aligned address; low log2(XLEN/8) bits are 0.
- bus_be  out  XLEN/8  byte enables.
- bus_wdata  out  XLEN  lane-shifted store data.
- bus_rdata  in  XLEN  full-word read data; sampled when `bus_ack` is high.
- bus_ack  in  1  access complete; meaningful only while `bus_en` is high.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready` = 1.
  - Accept on `req_valid`. Register write, size, address and data.
  - Compute offset = addr mod (XLEN/8).
- Checks at accept, in priority order:
  - Illegal size → RESP, err 3. Illegal means `req_size[1:0]` > log2(XLEN/8), or `req_size[2]` = 1 with a store or with full-width size.
  - Misaligned → RESP, err 1. Misaligned means offset is not a multiple of the access byte count.
  - No bus cycle is issued for either error.
- Otherwise → ACCESS:
  - `bus_en` = 1.
  - `bus_be` = ((1 << bytes) − 1) << offset.
  - `bus_wdata` = `req_wdata` << (8·offset).
  - Clear the wait counter.
- ACCESS:
  - If `bus_ack` = 1, capture data and go to RESP with err 0.
  - Otherwise increment the counter. When the counter equals TIMEOUT−1 with no ack, go to RESP with err 2.
- Load data path: raw = `bus_rdata` >> (8·offset), truncated to the access width. The result is sign-extended from its MSB unless `req_size[2]` = 1, in which case it is zero-extended.
- RESP:
  - `resp_valid` = 1 for exactly one cycle. There is no backpressure.
  - Then go to IDLE.
- `resp_rdata` and `resp_err` hold their values until the next RESP.
- A `bus_ack` arriving outside ACCESS is ignored, including a late ack after a timeout.

## Timing
- Reset (`rst` low), asynchronous:
  - State = IDLE, so `req_ready` = 1.
  - `resp_valid`, `bus_en`, `bus_wr`, `bus_be`, `bus_addr`, `bus_wdata`, `resp_rdata`, `resp_err` = 0. Counter = 0.
  - Reset mid-access drops `bus_en` immediately and produces no response.
- All bus and response outputs are registered. `req_ready` decodes the state only.
- Accept in cycle 0 → `bus_en` high from cycle 1 → ack in cycle k (k ≥ 1) → `resp_valid` in cycle k+1 → `req_ready` in cycle k+2.
  - Minimum load/store latency is 2 cycles, accept to `resp_valid`.
  - Error latency is 1 cycle.
- Timeout: with no ack, `bus_en` is high for exactly TIMEOUT cycles. `resp_valid` with err 2 follows the next cycle.
- `bus_*` signals are stable for the whole of ACCESS and return to 0 on leaving it.
- A request presented while not in IDLE is not accepted. The requester must hold it.

## Structure
- Shared package `cpu.vh` gains:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - unsigned flag bit index;
  - error codes ERR_OK/ERR_MISALIGN/ERR_TIMEOUT/ERR_SIZE;
  - FSM state constants.
- Sub-module `load_extend` (combinational): takes raw word, offset, size and unsigned flag; returns extended data. It is reused by any future cache fill path.

## Test plan
- XLEN=32, LW at 0x100 with `bus_rdata`=0xDEADBEEF and ack on cycle 1 → `bus_be`=4'b1111, `bus_addr`=0x100, `resp_valid` at cycle 2, `resp_rdata`=0xDEADBEEF, err 0.
- LB at 0x103 with `bus_rdata`=0x80123456 → `bus_be`=4'b1000, `resp_rdata`=0xFFFFFF80. Same access as LBU → 0x00000080.
- SH of 0x0000ABCD at 0x202 → `bus_wr`=1, `bus_be`=4'b1100, `bus_wdata`=0xABCD0000, `bus_addr`=0x200.
- LW at 0x101 → no `bus_en`, `resp_valid` next cycle with err 1. Size 3 at XLEN=32 → err 3.
- TIMEOUT=4, no ack → `bus_en` high exactly 4 cycles, then err 2. An ack one cycle later is ignored and `req_ready`=1.
- Assert `rst` low during ACCESS → `bus_en` drops asynchronously, no `resp_valid`. After release, an LW completes normally.

Source files
------------

// File: rtl/load_store_ctrl_pkg.sv
// ---- load_store_ctrl_pkg : shared encodings for the load/store controller (rev 1.0) ----
`default_nettype none

package load_store_ctrl_pkg;

   // req_size[1:0] is log2 of the access byte count
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam int UNS_BIT = 2;

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_SIZE     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   function automatic logic [7:0] lane_mask(input logic [1:0] lg_size);
      logic [7:0] m;
      case (lg_size)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         SZ_D:    m = 8'hFF;
         default: m = 8'h00;
      endcase
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_ctrl_if.sv
// ---- load_store_ctrl_if : CPU request/response and memory bus signals (rev 1.0) ----
`default_nettype none

interface load_store_ctrl_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) ();
   logic                req_valid;
   logic                req_ready;
   logic                req_wr;
   logic [2:0]          req_size;
   logic [ADDR_W-1:0]   req_addr;
   logic [XLEN-1:0]     req_wdata;
   logic                resp_valid;
   logic [XLEN-1:0]     resp_rdata;
   logic [1:0]          resp_err;
   logic                bus_en;
   logic                bus_wr;
   logic [ADDR_W-1:0]   bus_addr;
   logic [XLEN/8-1:0]   bus_be;
   logic [XLEN-1:0]     bus_wdata;
   logic [XLEN-1:0]     bus_rdata;
   logic                bus_ack;

   // master: requester and memory model; slave: the controller
   modport master (
      output req_valid, req_wr, req_size, req_addr, req_wdata, bus_rdata, bus_ack,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             bus_en, bus_wr, bus_addr, bus_be, bus_wdata
   );

   modport slave (
      input  req_valid, req_wr, req_size, req_addr, req_wdata, bus_rdata, bus_ack,
      output req_ready, resp_valid, resp_rdata, resp_err,
             bus_en, bus_wr, bus_addr, bus_be, bus_wdata
   );
endinterface

`default_nettype wire

// File: rtl/load_store_ctrl_extend.sv
// ---- load_extend : lane-shift and sign/zero-extend a raw bus word (rev 1.0) ----
`default_nettype none

module load_extend
   import load_store_ctrl_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int OFF_W = $clog2(XLEN/8)
) (
   input  logic [XLEN-1:0]  raw,
   input  logic [OFF_W-1:0] off,
   input  logic [1:0]       lg_size,
   input  logic             uns,
   output logic [XLEN-1:0]  data
);
   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted = raw >> {off, 3'b000};
      data    = shifted;
      case (lg_size)
         SZ_B: data = uns ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
         SZ_H: data = uns ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
         SZ_W: data = uns ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
         SZ_D: data = shifted;
         default: data = shifted;
      endcase
   end
endmodule

`default_nettype wire

// File: rtl/load_store_ctrl.sv
// ---- load_store_ctrl : handshaked load/store controller with bus timeout (rev 1.0) ----
`default_nettype none

module load_store_ctrl
   import load_store_ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                CLK,
   input  logic                rst,
   load_store_ctrl_if.slave    lsc
);
   localparam int         NB     = XLEN / 8;
   localparam int         OFF_W  = $clog2(NB);
   localparam logic [1:0] SZ_MAX = 2'(OFF_W);

   state_t              state, state_nxt;
   logic                accept, start, finish;
   logic [1:0]          err_nxt;

   logic [OFF_W-1:0]    req_off;
   logic [1:0]          req_lg;
   logic                size_illegal, misalign;

   logic                r_wr;
   logic [2:0]          r_size;
   logic [OFF_W-1:0]    r_off;
   logic [7:0]          r_cnt;
   logic                r_bus_en, r_bus_wr;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic [NB-1:0]       r_bus_be;
   logic [XLEN-1:0]     r_bus_wdata;
   logic                r_resp_valid;
   logic [XLEN-1:0]     r_resp_rdata;
   logic [1:0]          r_resp_err;
   logic [XLEN-1:0]     ext_data;

   assign req_off = lsc.req_addr[OFF_W-1:0];
   assign req_lg  = lsc.req_size[1:0];

   // Unsigned loads of full width are meaningless, and stores have no unsigned form
   assign size_illegal = (req_lg > SZ_MAX) ||
                         (lsc.req_size[UNS_BIT] && (lsc.req_wr || (req_lg == SZ_MAX)));
   assign misalign     = |(req_off & OFF_W'((4'd1 << req_lg) - 4'd1));

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      start     = 1'b0;
      finish    = 1'b0;
      err_nxt   = ERR_OK;
      case (state)
         ST_IDLE: begin
            if (lsc.req_valid) begin
               accept = 1'b1;
               if (size_illegal) begin
                  state_nxt = ST_RESP;
                  finish    = 1'b1;
                  err_nxt   = ERR_SIZE;
               end else if (misalign) begin
                  state_nxt = ST_RESP;
                  finish    = 1'b1;
                  err_nxt   = ERR_MISALIGN;
               end else begin
                  state_nxt = ST_ACCESS;
                  start     = 1'b1;
               end
            end
         end
         ST_ACCESS: begin
            if (lsc.bus_ack) begin
               state_nxt = ST_RESP;
               finish    = 1'b1;
            end else if (r_cnt == 8'(TIMEOUT - 1)) begin
               state_nxt = ST_RESP;
               finish    = 1'b1;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   load_extend #(.XLEN(XLEN), .OFF_W(OFF_W)) u_extend (
      .raw     (lsc.bus_rdata),
      .off     (r_off),
      .lg_size (r_size[1:0]),
      .uns     (r_size[UNS_BIT]),
      .data    (ext_data)
   );

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         r_wr         <= 1'b0;
         r_size       <= '0;
         r_off        <= '0;
         r_cnt        <= '0;
         r_bus_en     <= 1'b0;
         r_bus_wr     <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_be     <= '0;
         r_bus_wdata  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= ERR_OK;
      end else begin
         r_resp_valid <= finish;

         if (accept) begin
            r_wr   <= lsc.req_wr;
            r_size <= lsc.req_size;
            r_off  <= req_off;
            r_cnt  <= '0;
         end else if (state == ST_ACCESS) begin
            r_cnt  <= r_cnt + 8'd1;
         end

         // Bus outputs are loaded once at accept and held flat through ACCESS
         if (start) begin
            r_bus_en    <= 1'b1;
            r_bus_wr    <= lsc.req_wr;
            r_bus_addr  <= {lsc.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            r_bus_be    <= NB'(lane_mask(req_lg) << req_off);
            r_bus_wdata <= lsc.req_wdata << {req_off, 3'b000};
         end else if (state_nxt != ST_ACCESS) begin
            r_bus_en    <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
         end

         if (finish) begin
            r_resp_err   <= err_nxt;
            r_resp_rdata <= ((err_nxt == ERR_OK) && !r_wr) ? ext_data : '0;
         end
      end
   end

   assign lsc.req_ready  = (state == ST_IDLE);
   assign lsc.resp_valid = r_resp_valid;
   assign lsc.resp_rdata = r_resp_rdata;
   assign lsc.resp_err   = r_resp_err;
   assign lsc.bus_en     = r_bus_en;
   assign lsc.bus_wr     = r_bus_wr;
   assign lsc.bus_addr   = r_bus_addr;
   assign lsc.bus_be     = r_bus_be;
   assign lsc.bus_wdata  = r_bus_wdata;
endmodule

`default_nettype wire

// File: tb/tb_load_store_ctrl.sv
// ---- tb_load_store_ctrl : directed self-checking bench for load_store_ctrl (rev 1.0) ----
`default_nettype none

module tb_load_store_ctrl;
   localparam int T = 4;

   logic CLK = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 CLK = ~CLK;

   load_store_ctrl_if #(.XLEN(32), .ADDR_W(32)) lsc ();

   load_store_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT(T)) dut (
      .CLK (CLK),
      .rst (rst),
      .lsc (lsc)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One request; ack in cycle ack (0 = never). Bus fields checked every ACCESS cycle.
   task automatic lsu_op(input string tag, input logic wr, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack, input logic late_ack,
                         input logic [3:0] exp_be, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_err);
      int  exp_lat, exp_en, c, en_cnt;
      bit  seen;
      if (exp_err == 2'd1 || exp_err == 2'd3) begin exp_lat = 1;     exp_en = 0; end
      else if (exp_err == 2'd2)               begin exp_lat = T + 1; exp_en = T; end
      else                                    begin exp_lat = ack + 1; exp_en = ack; end

      @(negedge CLK);
      check({tag, "_ready"}, lsc.req_ready, 1'b1);
      lsc.req_valid = 1'b1; lsc.req_wr = wr; lsc.req_size = size;
      lsc.req_addr = addr;  lsc.req_wdata = wdata;
      @(posedge CLK);
      #1 lsc.req_valid = 1'b0;

      c = 1; en_cnt = 0; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (lsc.resp_valid) begin seen = 1'b1; break; end
         en_cnt += int'(lsc.bus_en);
         if (c <= exp_en) begin
            check({tag, "_be"},   lsc.bus_be,   exp_be);
            check({tag, "_addr"}, lsc.bus_addr, exp_addr);
            if (c == 1) begin
               check({tag, "_wr"},    lsc.bus_wr,    wr);
               check({tag, "_wdata"}, lsc.bus_wdata, exp_wdata);
            end
         end
         lsc.bus_ack   = (c == ack);
         lsc.bus_rdata = rdata;
         c++;
      end
      lsc.bus_ack = 1'b0;
      check({tag, "_resp_seen"}, seen, 1'b1);
      check({tag, "_latency"},   c, exp_lat);
      check({tag, "_en_cycles"}, en_cnt, exp_en);
      check({tag, "_err"},       lsc.resp_err, exp_err);
      check({tag, "_rdata"},     lsc.resp_rdata, exp_rdata);
      check({tag, "_en_off"},    lsc.bus_en, 1'b0);

      lsc.bus_ack = late_ack;
      @(negedge CLK);
      lsc.bus_ack = 1'b0;
      check({tag, "_pulse1"},    lsc.resp_valid, 1'b0);
      check({tag, "_idle"},      lsc.req_ready, 1'b1);
      check({tag, "_bus_idle"},  lsc.bus_en, 1'b0);
      check({tag, "_hold_err"},  lsc.resp_err, exp_err);
   endtask

   initial begin
      lsc.req_valid = 1'b0; lsc.req_wr = 1'b0; lsc.req_size = 3'd0;
      lsc.req_addr  = '0;   lsc.req_wdata = '0;
      lsc.bus_rdata = '0;   lsc.bus_ack = 1'b0;

      repeat (2) @(negedge CLK);
      check("rst_ready", lsc.req_ready,  1'b1);
      check("rst_rv",    lsc.resp_valid, 1'b0);
      check("rst_en",    lsc.bus_en,     1'b0);
      check("rst_be",    lsc.bus_be,     4'h0);
      check("rst_addr",  lsc.bus_addr,   32'h0);
      check("rst_wdata", lsc.bus_wdata,  32'h0);
      check("rst_rdata", lsc.resp_rdata, 32'h0);
      check("rst_err",   lsc.resp_err,   2'd0);
      rst = 1'b1;

      //     tag     wr    size   addr          wdata         rdata         ack late be     bus_addr      bus_wdata     resp_rdata    err
      lsu_op("lw",   1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 1, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 2'd0);
      lsu_op("lb",   1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80123456, 1, 1'b0, 4'h8, 32'h0000_0100, 32'h0,        32'hFFFFFF80, 2'd0);
      lsu_op("lbu",  1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h80123456, 1, 1'b0, 4'h8, 32'h0000_0100, 32'h0,        32'h00000080, 2'd0);
      lsu_op("lh_hi",1'b0, 3'd1, 32'h0000_0102, 32'h0,        32'h7FFF1234, 2, 1'b0, 4'hC, 32'h0000_0100, 32'h0,        32'h00007FFF, 2'd0);
      lsu_op("lh_lo",1'b0, 3'd1, 32'h0000_0100, 32'h0,        32'h00008001, 1, 1'b0, 4'h3, 32'h0000_0100, 32'h0,        32'hFFFF8001, 2'd0);
      lsu_op("lhu",  1'b0, 3'd5, 32'h0000_0100, 32'h0,        32'h00008001, 1, 1'b0, 4'h3, 32'h0000_0100, 32'h0,        32'h00008001, 2'd0);
      lsu_op("sh",   1'b1, 3'd1, 32'h0000_0202, 32'h0000ABCD, 32'hFFFFFFFF, 3, 1'b0, 4'hC, 32'h0000_0200, 32'hABCD0000, 32'h0,        2'd0);
      lsu_op("sb",   1'b1, 3'd0, 32'h0000_0001, 32'h000000A5, 32'h0,        1, 1'b0, 4'h2, 32'h0000_0000, 32'h0000A500, 32'h0,        2'd0);
      lsu_op("sw",   1'b1, 3'd2, 32'h0000_0404, 32'h11223344, 32'h0,        1, 1'b0, 4'hF, 32'h0000_0404, 32'h11223344, 32'h0,        2'd0);
      lsu_op("lw_mis",1'b0,3'd2, 32'h0000_0101, 32'h0,        32'h0,        1, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0,        2'd1);
      lsu_op("lh_mis",1'b0,3'd1, 32'h0000_0101, 32'h0,        32'h0,        1, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0,        2'd1);
      lsu_op("sz3",  1'b0, 3'd3, 32'h0000_0101, 32'h0,        32'h0,        1, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0,        2'd3);
      lsu_op("lwu",  1'b0, 3'd6, 32'h0000_0100, 32'h0,        32'h0,        1, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0,        2'd3);
      lsu_op("sbu",  1'b1, 3'd4, 32'h0000_0100, 32'h0,        32'h0,        1, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0,        2'd3);
      lsu_op("tmo",  1'b0, 3'd2, 32'h0000_0500, 32'h0,        32'hCAFEF00D, 0, 1'b1, 4'hF, 32'h0000_0500, 32'h0,        32'h0,        2'd2);

      // Asynchronous reset in the middle of an access
      @(negedge CLK);
      lsc.req_valid = 1'b1; lsc.req_wr = 1'b0; lsc.req_size = 3'd2;
      lsc.req_addr = 32'h0000_0300; lsc.req_wdata = '0;
      @(posedge CLK);
      #1 lsc.req_valid = 1'b0;
      @(negedge CLK);
      check("mid_en_before", lsc.bus_en, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("mid_en_drop", lsc.bus_en,    1'b0);
      check("mid_ready",   lsc.req_ready, 1'b1);
      @(negedge CLK);
      check("mid_no_resp", lsc.resp_valid, 1'b0);
      rst = 1'b1;
      @(negedge CLK);
      check("post_no_resp", lsc.resp_valid, 1'b0);
      lsu_op("lw_post", 1'b0, 3'd2, 32'h0000_0300, 32'h0, 32'h12345678, 2, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 32'h12345678, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

`default_nettype wire
